// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and state type for the memory responder
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single write port, single registered read port storage
module mem_array #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write port; contents are cleared by the owner's sweep, not by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value whenever no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - init-sweep memory responder with read/write conflict tracking
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              rw_err,
  output logic [3:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              rw_err_q, rw_err_d;
  logic [3:0]        err_cnt_q, err_cnt_d;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Next-state, sweep pointer, array strobes and error bookkeeping.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rw_err_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    unique case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (read && write) begin
          rw_err_d = 1'b1;
          if (err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'd1;
          end
        end else if (write) begin
          mem_we = 1'b1;
        end else if (read) begin
          mem_re = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
    // Anything in flight while reset is held is dropped.
    if (rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
    ready_d = (state_d == RUN);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      rw_err_q  <= 1'b0;
      err_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      rw_err_q  <= rw_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (mem_re),
    .raddr_i(addr),
    .rdata_o(data_out)
  );

  assign ready   = ready_q;
  assign rw_err  = rw_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready;
  logic       rw_err;
  logic [3:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .ADDR_W(5),
    .DATA_W(8),
    .DEPTH (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .ready   (ready),
    .rw_err  (rw_err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int found;
    int cnt;
    int exp_cnt;

    idle();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_data_out", 32'(data_out), 32'h00);
    check_eq("rst_ready", 32'(ready), 32'h0);
    check_eq("rst_rw_err", 32'(rw_err), 32'h0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;

    // Sweep: strobes during INIT must be ignored, ready rises after edge 32.
    for (int i = 1; i <= 32; i++) begin
      if (i >= 6 && i < 20) begin
        write = 1'b1; read = 1'b0; addr = 5'd4; data_in = 8'hA5;
      end else if (i >= 20 && i < 26) begin
        write = 1'b1; read = 1'b1; addr = 5'd4; data_in = 8'hA5;
      end else if (i >= 26) begin
        write = 1'b0; read = 1'b1; addr = 5'd4;
      end else begin
        idle();
      end
      tick();
      check_eq($sformatf("init_ready_%0d", i), 32'(ready), (i == 32) ? 32'h1 : 32'h0);
      check_eq($sformatf("init_rw_err_%0d", i), 32'(rw_err), 32'h0);
      check_eq($sformatf("init_data_out_%0d", i), 32'(data_out), 32'h00);
      check_eq($sformatf("init_err_cnt_%0d", i), 32'(err_cnt), 32'h0);
    end
    idle();

    // Every location reads back cleared, including addr 4 written during INIT.
    for (int a = 0; a < 32; a++) begin
      read = 1'b1; addr = 5'(a);
      tick();
      check_eq($sformatf("clear_rd_%0d", a), 32'(data_out), 32'h00);
    end
    idle();

    // Write then read next cycle.
    write = 1'b1; addr = 5'd3; data_in = 8'h5A;
    tick();
    check_eq("wr3_data_out_held", 32'(data_out), 32'h00);
    write = 1'b0; read = 1'b1; addr = 5'd3;
    tick();
    check_eq("rd3_after_wr", 32'(data_out), 32'h5A);
    idle();

    // Pattern fill data == address, then back-to-back readback.
    for (int a = 0; a < 32; a++) begin
      write = 1'b1; addr = 5'(a); data_in = 8'(a);
      tick();
    end
    idle();
    check_eq("fill_data_out_held", 32'(data_out), 32'h5A);
    for (int a = 0; a < 32; a++) begin
      read = 1'b1; addr = 5'(a);
      tick();
      check_eq($sformatf("b2b_rd_%0d", a), 32'(data_out), 32'(a));
    end
    idle();

    // Illegal read+write at addr 7.
    read = 1'b1; write = 1'b1; addr = 5'd7; data_in = 8'hFF;
    tick();
    check_eq("rw_err_pulse", 32'(rw_err), 32'h1);
    check_eq("err_cnt_one", 32'(err_cnt), 32'h1);
    check_eq("rw_data_out_held", 32'(data_out), 32'h1F);
    idle();
    tick();
    check_eq("rw_err_drop", 32'(rw_err), 32'h0);
    read = 1'b1; addr = 5'd7;
    tick();
    check_eq("mem7_unchanged", 32'(data_out), 32'h07);
    idle();

    exp_cnt = 1;
    for (int k = 0; k < 16; k++) begin
      read = 1'b1; write = 1'b1; addr = 5'd7; data_in = 8'hFF;
      tick();
      if (exp_cnt < 15) exp_cnt++;
      check_eq($sformatf("sat_err_cnt_%0d", k), 32'(err_cnt), 32'(exp_cnt));
      check_eq($sformatf("sat_rw_err_%0d", k), 32'(rw_err), 32'h1);
    end
    idle();
    tick();
    check_eq("sat_rw_err_drop", 32'(rw_err), 32'h0);
    check_eq("sat_err_cnt_final", 32'(err_cnt), 32'hF);
    read = 1'b1; addr = 5'd7;
    tick();
    check_eq("mem7_after_sat", 32'(data_out), 32'h07);
    idle();

    // Reset from RUN, then again at INIT cycle 10; sweep restarts in full.
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst2_err_cnt", 32'(err_cnt), 32'h0);
    check_eq("rst2_data_out", 32'(data_out), 32'h00);
    check_eq("rst2_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("mid_sweep_ready", 32'(ready), 32'h0);
    rst = 1'b1;
    write = 1'b1; addr = 5'd9; data_in = 8'h3C;
    tick();
    rst = 1'b0;
    idle();
    found = 0;
    cnt   = 0;
    for (int k = 1; k <= 64 && found == 0; k++) begin
      tick();
      if (ready) begin
        found = 1;
        cnt   = k;
      end
    end
    check_eq("restart_sweep_len", 32'(cnt), 32'd32);

    // Sweep cleared the earlier pattern.
    read = 1'b1; addr = 5'd5;
    tick();
    check_eq("post_rst_rd5", 32'(data_out), 32'h00);
    addr = 5'd9;
    tick();
    check_eq("post_rst_rd9", 32'(data_out), 32'h00);
    addr = 5'd31;
    tick();
    check_eq("post_rst_rd31", 32'(data_out), 32'h00);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 5, address width.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W), number of locations.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 read  input  1  read strobe, sampled at rising clk.
REQ-007 write  input  1  write strobe, sampled at rising clk.
REQ-008 addr  input  ADDR_W  access address.
REQ-009 data_in  input  DATA_W  write data TO memory.
REQ-010 data_out  output  DATA_W  read data FROM memory, registered.
REQ-011 ready  output  1  high when the init sweep is complete and accesses are accepted.
REQ-012 rw_err  output  1  one-cycle pulse on an illegal simultaneous read+write.
REQ-013 err_cnt  output  4  count of illegal accesses, saturating at 15.

Function
REQ-014 FSM states SHALL be INIT and RUN; rst SHALL force INIT with sweep pointer 0.
REQ-015 INIT: each cycle write 0 to mem[ptr], ptr++; on the cycle ptr==DEPTH-1 is cleared, go to RUN; INIT SHALL last exactly DEPTH cycles.
REQ-016 ready SHALL be 0 in INIT and 1 in RUN, registered, rising in the cycle after the last clear.
REQ-017 In INIT, read/write SHALL be ignored: no array update, data_out held, no error.
REQ-018 RUN, write=1 read=0: mem[addr] <= data_in at that edge; data_out unchanged.
REQ-019 RUN, read=1 write=0: data_out <= mem[addr] at that edge (latency 1 cycle from strobe sample).
REQ-020 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-021 Back-to-back reads on consecutive cycles SHALL each be serviced; throughput one access per cycle.
REQ-022 RUN, read=1 write=1: no array update, data_out held, rw_err=1 for exactly that next cycle, err_cnt += 1 unless already 15.
REQ-023 RUN, read=0 write=0: array and data_out held, rw_err=0.
REQ-024 Address wrap: none needed; full ADDR_W range is valid when DEPTH==2**ADDR_W.

Reset
REQ-025 On rst: data_out=0, ready=0, rw_err=0, err_cnt=0, state=INIT, ptr=0.
REQ-026 rst asserted mid-sweep or mid-RUN SHALL restart the full DEPTH-cycle sweep after deassertion; pending accesses are discarded.
REQ-027 Array contents SHALL not be relied on until ready=1.

Structure
REQ-028 Package mem_pkg SHALL hold ADDR_W/DATA_W/DEPTH defaults and the state enum (INIT, RUN).
REQ-029 Storage SHALL be a sub-module mem_array (single write port, single registered read port); the FSM, error logic and counters live in mem_responder.

Verification
REQ-030 Assert rst 2 cycles, release -> ready=0 for 32 cycles then 1; reads of addr 0..31 -> data_out 8'h00.
REQ-031 RUN: write 8'h5A @addr 3, next cycle read addr 3 -> data_out 8'h5A one cycle after read strobe.
REQ-032 Write data=address for addr 0..31, then read 0..31 back-to-back -> data_out equals address each cycle, latency 1.
REQ-033 RUN: read=write=1 @addr 7 with data_in 8'hFF -> mem[7] unchanged, rw_err one-cycle pulse, err_cnt=1; 16 repeats -> err_cnt stays 15.
REQ-034 rst asserted at INIT cycle 10 -> ptr restarts; ready rises exactly 32 cycles after rst release.
REQ-035 Write 8'hA5 @addr 4 during INIT -> ignored; after ready, read addr 4 -> 8'h00.
